// File: rtl/mtr_duty_sched.sv
// Duty scheduler and over-current supervisor for one PWM11 channel.
// Define DUTY_SLEW_EN to enable the per-period slew limiter; otherwise duty jumps to target.
module mtr_duty_sched #(
   parameter logic [10:0] SLEW      = 11'd16,
   parameter logic [10:0] DUTY_MIN  = 11'h080,
   parameter logic [10:0] DUTY_MAX  = 11'h77F,
   parameter int unsigned OVR_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en_steer,
   input  logic [10:0] duty_req,
   input  logic        PWM_synch,
   input  logic        ovr_I_blank,
   input  logic        OVR_I,
   input  logic        clr_fault,
   output logic [10:0] duty,
   output logic        fault,
   output logic        active
);

   localparam int unsigned DW = 11;
   localparam int unsigned CW = 4;
   localparam logic [DW-1:0] DUTY_ZERO = 11'h400;
   localparam logic [CW-1:0] OVR_LIM   = CW'(OVR_LIMIT);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_FAULT  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] duty_q, duty_d;
   logic          fault_q, fault_d;
   logic          active_q, active_d;
   logic          ovr_s1_q, ovr_s2_q;
   logic          blank_d1_q, blank_d2_q;
   logic          ovr_seen_q, ovr_seen_d;
   logic [CW-1:0] ovr_cnt_q, ovr_cnt_d;
   logic [CW-1:0] cnt_upd_c;
   logic [DW-1:0] tgt_c, step_c;
   logic          qual_c;

   if (OVR_LIMIT < 1 || OVR_LIMIT > 15) begin : g_bad_limit
      $error("OVR_LIMIT must lie in 1..15");
   end
   if (DUTY_MIN > DUTY_MAX) begin : g_bad_clamp
      $error("DUTY_MIN must not exceed DUTY_MAX");
   end
   if (SLEW == '0) begin : g_bad_slew
      $error("SLEW must be non-zero");
   end

   // Clamped target; a disabled drive always aims for zero torque
   always_comb begin
      tgt_c = DUTY_ZERO;
      if (en_steer) begin
         if (duty_req < DUTY_MIN)      tgt_c = DUTY_MIN;
         else if (duty_req > DUTY_MAX) tgt_c = DUTY_MAX;
         else                          tgt_c = duty_req;
      end
   end

`ifdef DUTY_SLEW_EN
   localparam logic signed [DW:0] SLEW_S = $signed({1'b0, SLEW});
   logic signed [DW:0] diff_c;

   // Step never overshoots: only a gap larger than SLEW takes a partial step
   always_comb begin
      diff_c = $signed({1'b0, tgt_c}) - $signed({1'b0, duty_q});
      if (diff_c > SLEW_S)       step_c = duty_q + SLEW;
      else if (diff_c < -SLEW_S) step_c = duty_q - SLEW;
      else                       step_c = tgt_c;
   end
`else
   always_comb step_c = tgt_c;
`endif

   // Blank is delayed by the same depth as the OVR_I synchronizer
   assign qual_c    = ovr_s2_q & ~blank_d2_q;
   assign cnt_upd_c = ovr_seen_q ? ovr_cnt_q + CW'(1) : '0;

   always_comb begin
      state_d    = state_q;
      duty_d     = duty_q;
      fault_d    = fault_q;
      ovr_seen_d = ovr_seen_q | qual_c;
      ovr_cnt_d  = ovr_cnt_q;
      case (state_q)
         ST_IDLE, ST_ACTIVE: begin
            if (PWM_synch) begin
               ovr_seen_d = qual_c;
               ovr_cnt_d  = cnt_upd_c;
               if (cnt_upd_c == OVR_LIM) begin
                  state_d   = ST_FAULT;
                  fault_d   = 1'b1;
                  duty_d    = DUTY_ZERO;
                  ovr_cnt_d = '0;
               end else begin
                  duty_d = step_c;
                  if (state_q == ST_IDLE && en_steer)
                     state_d = ST_ACTIVE;
                  else if (state_q == ST_ACTIVE && !en_steer && duty_q == DUTY_ZERO)
                     state_d = ST_IDLE;
               end
            end
         end
         ST_FAULT: begin
            duty_d     = DUTY_ZERO;
            ovr_seen_d = 1'b0;
            ovr_cnt_d  = '0;
            if (clr_fault && !en_steer) begin
               state_d = ST_IDLE;
               fault_d = 1'b0;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            duty_d     = DUTY_ZERO;
            fault_d    = 1'b0;
            ovr_seen_d = 1'b0;
            ovr_cnt_d  = '0;
         end
      endcase
      active_d = (state_d == ST_ACTIVE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         duty_q     <= DUTY_ZERO;
         fault_q    <= 1'b0;
         active_q   <= 1'b0;
         ovr_s1_q   <= 1'b0;
         ovr_s2_q   <= 1'b0;
         blank_d1_q <= 1'b0;
         blank_d2_q <= 1'b0;
         ovr_seen_q <= 1'b0;
         ovr_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         duty_q     <= duty_d;
         fault_q    <= fault_d;
         active_q   <= active_d;
         ovr_s1_q   <= OVR_I;
         ovr_s2_q   <= ovr_s1_q;
         blank_d1_q <= ovr_I_blank;
         blank_d2_q <= blank_d1_q;
         ovr_seen_q <= ovr_seen_d;
         ovr_cnt_q  <= ovr_cnt_d;
      end
   end

   assign duty   = duty_q;
   assign fault  = fault_q;
   assign active = active_q;

endmodule

// File: tb/tb_mtr_duty_sched.sv
// Scoreboard bench for mtr_duty_sched: each PWM_synch queues the expected duty/fault/active,
// a monitor pops and compares after the synch edge and checks duty is stable between synchs.
module tb_mtr_duty_sched;

   localparam int unsigned PER = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en_steer = 1'b0;
   logic [10:0] duty_req = 11'h400;
   logic        PWM_synch = 1'b0;
   logic        ovr_I_blank = 1'b0;
   logic        OVR_I = 1'b0;
   logic        clr_fault = 1'b0;
   logic [10:0] duty;
   logic        fault;
   logic        active;

   typedef struct packed {
      logic [10:0] duty;
      logic        fault;
      logic        active;
   } exp_t;

   exp_t        exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [10:0] last_duty = 11'h400;
   logic [10:0] m_duty = 11'h400;
   logic        m_fault = 1'b0;
   logic        m_active = 1'b0;
   logic [10:0] first_step;
   logic [10:0] dn [5];

   mtr_duty_sched dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_steer    (en_steer),
      .duty_req    (duty_req),
      .PWM_synch   (PWM_synch),
      .ovr_I_blank (ovr_I_blank),
      .OVR_I       (OVR_I),
      .clr_fault   (clr_fault),
      .duty        (duty),
      .fault       (fault),
      .active      (active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   // Expected next duty for one period, default SLEW = 16
   function automatic logic [10:0] m_step(input logic [10:0] cur, input logic [10:0] tgt);
`ifdef DUTY_SLEW_EN
      int c;
      int t;
      c = int'(cur);
      t = int'(tgt);
      if (t > c + 16) return 11'(c + 16);
      if (t < c - 16) return 11'(c - 16);
`endif
      return tgt;
   endfunction

   // One PWM period (optional over-current / blank pulses) closed by a synch pulse
   task automatic cyc(input bit ovr, input bit blk, input bit trip);
      logic [10:0] tgt;
      for (int i = 0; i < PER; i++) begin
         @(negedge clk);
         OVR_I       = ovr && (i == 2);
         ovr_I_blank = blk && (i >= 1) && (i <= 3);
      end
      @(negedge clk);
      OVR_I       = 1'b0;
      ovr_I_blank = 1'b0;
      if (!m_fault) begin
         if (trip) begin
            m_fault  = 1'b1;
            m_active = 1'b0;
            m_duty   = 11'h400;
         end else begin
            if (!en_steer)               tgt = 11'h400;
            else if (duty_req < 11'h080) tgt = 11'h080;
            else if (duty_req > 11'h77F) tgt = 11'h77F;
            else                         tgt = duty_req;
            if (!m_active) begin
               if (en_steer) m_active = 1'b1;
            end else if (!en_steer && m_duty == 11'h400) begin
               m_active = 1'b0;
            end
            m_duty = m_step(m_duty, tgt);
         end
      end
      exp_q.push_back('{m_duty, m_fault, m_active});
      PWM_synch = 1'b1;
      @(negedge clk);
      PWM_synch = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      logic syn;
      forever begin
         @(posedge clk);
         syn = PWM_synch;
         #1;
         if (!rst_n) continue;
         if (syn) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL synch_unqueued: duty %0h seen with no expectation queued", duty);
            end else begin
               e = exp_q.pop_front();
               chk("synch_duty", 32'(duty), 32'(e.duty));
               chk("synch_fault", 32'(fault), 32'(e.fault));
               chk("synch_active", 32'(active), 32'(e.active));
               last_duty = e.duty;
            end
         end else begin
            chk("duty_stable", 32'(duty), 32'(last_duty));
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got %0d vectors, expected completion", n_vec);
      $fatal(1, "timeout");
   end

   initial begin : stim
`ifdef DUTY_SLEW_EN
      first_step = 11'h410;
      dn[0] = 11'h440; dn[1] = 11'h430; dn[2] = 11'h420; dn[3] = 11'h410; dn[4] = 11'h400;
`else
      first_step = 11'h500;
      dn[0] = 11'h400; dn[1] = 11'h400; dn[2] = 11'h400; dn[3] = 11'h400; dn[4] = 11'h400;
`endif
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_duty", 32'(duty), 32'h400);
      chk("rst_fault", 32'(fault), 32'h0);
      chk("rst_active", 32'(active), 32'h0);

      // Enable and ramp to 0x500
      en_steer = 1'b1;
      duty_req = 11'h500;
      cyc(0, 0, 0);
      chk("first_step", 32'(duty), 32'(first_step));
      chk("first_active", 32'(active), 32'h1);
      repeat (15) cyc(0, 0, 0);
      chk("ramp_500", 32'(duty), 32'h500);

      // Clamp high and low
      duty_req = 11'h7FF;
      for (int k = 0; k < 80 && m_duty != 11'h77F; k++) cyc(0, 0, 0);
      cyc(0, 0, 0);
      chk("clamp_hi", 32'(duty), 32'h77F);
      duty_req = 11'h000;
      for (int k = 0; k < 150 && m_duty != 11'h080; k++) cyc(0, 0, 0);
      cyc(0, 0, 0);
      chk("clamp_lo", 32'(duty), 32'h080);

      // Over-current only inside blank windows
      repeat (10) cyc(1, 1, 0);
      chk("blank_fault", 32'(fault), 32'h0);

      // Move to 0x600, then three hits, a clean period, one hit: no trip
      duty_req = 11'h600;
      for (int k = 0; k < 120 && m_duty != 11'h600; k++) cyc(0, 0, 0);
      chk("at_600", 32'(duty), 32'h600);
      repeat (3) cyc(1, 0, 0);
      cyc(0, 0, 0);
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      chk("no_trip_fault", 32'(fault), 32'h0);
      chk("no_trip_duty", 32'(duty), 32'h600);

      // Four consecutive hits trip the fault
      repeat (3) cyc(1, 0, 0);
      cyc(1, 0, 1);
      chk("trip_fault", 32'(fault), 32'h1);
      chk("trip_duty", 32'(duty), 32'h400);
      chk("trip_active", 32'(active), 32'h0);
      cyc(0, 0, 0);
      chk("fault_hold_duty", 32'(duty), 32'h400);

      // Clear ignored while enabled, honoured once disabled
      clr_fault = 1'b1;
      @(negedge clk);
      clr_fault = 1'b0;
      @(negedge clk);
      chk("clr_ignored", 32'(fault), 32'h1);
      en_steer = 1'b0;
      @(negedge clk);
      clr_fault = 1'b1;
      @(negedge clk);
      clr_fault = 1'b0;
      m_fault  = 1'b0;
      m_active = 1'b0;
      chk("clr_fault", 32'(fault), 32'h0);
      chk("clr_active", 32'(active), 32'h0);

      // Ramp to 0x450, then disable and ramp down
      en_steer = 1'b1;
      duty_req = 11'h450;
      for (int k = 0; k < 10 && m_duty != 11'h450; k++) cyc(0, 0, 0);
      chk("at_450", 32'(duty), 32'h450);
      en_steer = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0);
         chk("ramp_down", 32'(duty), 32'(dn[i]));
      end
      cyc(0, 0, 0);
      chk("ramp_idle", 32'(active), 32'h0);

      // Asynchronous reset mid-operation
      en_steer = 1'b1;
      duty_req = 11'h600;
      repeat (3) cyc(0, 0, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst2_duty", 32'(duty), 32'h400);
      chk("rst2_fault", 32'(fault), 32'h0);
      chk("rst2_active", 32'(active), 32'h0);
      m_duty    = 11'h400;
      m_fault   = 1'b0;
      m_active  = 1'b0;
      last_duty = 11'h400;
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 0, 0);
      chk("resume_active", 32'(active), 32'h1);
      chk("resume_duty", 32'(duty), 32'(first_step == 11'h410 ? 11'h410 : 11'h600));

      repeat (3) @(negedge clk);
      chk("queue_drain", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
